// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store stage sitting behind the ALU.
// Takes one memory operation per request and runs it over a valid/ready
// data-memory port. It generates byte enables, replicates store data
// across the byte lanes, and extracts and extends load data. Misaligned
// accesses, illegal funct3 values and bus timeouts are reported as faults.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   start, is_store, funct3       operation request from execute
//   addr, store_data              effective byte address, rs2 value
//   stall                         pipeline hold (combinational from start)
//   done, load_data, fault        completion pulse, result, fault code
//   mem_req/we/addr/be/wdata      data-memory request
//   mem_ready, mem_rdata          data-memory response
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic [1:0]  fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] FLT_NONE     = 2'b00;
    localparam logic [1:0] FLT_MISALIGN = 2'b01;
    localparam logic [1:0] FLT_TIMEOUT  = 2'b10;
    localparam logic [1:0] FLT_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_store_q, is_store_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [1:0]         off_q, off_d;

    logic               done_d;
    logic [DATA_W-1:0]  load_data_d;
    logic [1:0]         fault_d;
    logic               mem_req_d;
    logic               mem_we_d;
    logic [DATA_W-1:0]  mem_addr_d;
    logic [BE_W-1:0]    mem_be_d;
    logic [DATA_W-1:0]  mem_wdata_d;

    logic               illegal_c, misalign_c, accept_c, go_req_c;
    logic [BE_W-1:0]    be_c;
    logic [DATA_W-1:0]  wdata_c;
    logic [DATA_W-1:0]  lane_c, ext_c;

    // Classify the incoming request; stall only for accesses that will reach the bus.
    always_comb begin
        if (is_store) begin
            illegal_c = funct3[2] || (funct3[1:0] == 2'b11);
        end else begin
            illegal_c = (funct3[1:0] == 2'b11) || (funct3 == 3'b110);
        end
        misalign_c = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        accept_c   = start && (state_q != REQ);
        go_req_c   = accept_c && !illegal_c && !misalign_c;
        stall      = go_req_c || (state_q == REQ);
    end

    // Byte enables and lane-replicated write data from the incoming request.
    always_comb begin
        case (funct3[1:0])
            2'b00: begin
                be_c    = 4'b0001 << addr[1:0];
                wdata_c = {4{store_data[7:0]}};
            end
            2'b01: begin
                be_c    = 4'b0011 << addr[1:0];
                wdata_c = {2{store_data[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = store_data;
            end
        endcase
    end

    // Load extraction: shift the addressed lane down, then extend by funct3.
    always_comb begin
        lane_c = mem_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  ext_c = {{24{lane_c[7]}}, lane_c[7:0]};
            3'b001:  ext_c = {{16{lane_c[15]}}, lane_c[15:0]};
            3'b100:  ext_c = {24'h0, lane_c[7:0]};
            3'b101:  ext_c = {16'h0, lane_c[15:0]};
            default: ext_c = lane_c;
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_store_d  = is_store_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        done_d      = 1'b0;
        fault_d     = FLT_NONE;
        load_data_d = load_data;
        mem_req_d   = 1'b0;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_be_d    = mem_be;
        mem_wdata_d = mem_wdata;

        case (state_q)
            REQ: begin
                if (mem_ready) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    load_data_d = is_store_q ? '0 : ext_c;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    fault_d     = FLT_TIMEOUT;
                    load_data_d = '0;
                end else begin
                    cnt_d     = cnt_q + CNT_W'(1);
                    mem_req_d = 1'b1;
                end
            end
            default: begin
                // IDLE and DONE both accept a new request.
                if (state_q == DONE) begin
                    state_d = IDLE;
                end
                if (accept_c) begin
                    is_store_d = is_store;
                    funct3_d   = funct3;
                    off_d      = addr[1:0];
                    if (illegal_c) begin
                        state_d     = DONE;
                        done_d      = 1'b1;
                        fault_d     = FLT_ILLEGAL;
                        load_data_d = '0;
                    end else if (misalign_c) begin
                        state_d     = DONE;
                        done_d      = 1'b1;
                        fault_d     = FLT_MISALIGN;
                        load_data_d = '0;
                    end else begin
                        state_d     = REQ;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store;
                        mem_addr_d  = {addr[31:2], 2'b00};
                        mem_be_d    = be_c;
                        mem_wdata_d = wdata_c;
                    end
                end
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            is_store_q <= 1'b0;
            funct3_q   <= '0;
            off_q      <= '0;
            done       <= 1'b0;
            load_data  <= '0;
            fault      <= FLT_NONE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_store_q <= is_store_d;
            funct3_q   <= funct3_d;
            off_q      <= off_d;
            done       <= done_d;
            load_data  <= load_data_d;
            fault      <= fault_d;
            mem_req    <= mem_req_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_be     <= mem_be_d;
            mem_wdata  <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit (TIMEOUT=4): directed table, randomized
// transactions against a byte-level reference model, and hand-written
// back-to-back and reset-during-request sequences.
module tb_load_store_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0;
    logic [31:0] store_data = '0;
    logic        stall;
    logic        done;
    logic [31:0] load_data;
    logic [1:0]  fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    load_store_unit #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store),
        .funct3(funct3), .addr(addr), .store_data(store_data),
        .stall(stall), .done(done), .load_data(load_data), .fault(fault),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        st;
        bit [2:0]  f3;
        bit [31:0] a;
        bit [31:0] sd;
        bit [31:0] rd;
        int        w;
        bit [1:0]  flt;
        bit [31:0] ld;
        bit [3:0]  be;
        bit [31:0] wd;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model: byte-level view of an RV32I access.
    function automatic void model(input bit st, input bit [2:0] f3, input bit [31:0] a,
                                  input bit [31:0] sd, input bit [31:0] rd, input int w,
                                  output bit [1:0] flt, output bit [31:0] ld,
                                  output bit [3:0] be, output bit [31:0] wd);
        int nb, off;
        bit legal;
        longint unsigned mask, val;
        legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        nb  = 1 << f3[1:0];
        off = int'(a % 32'd4);
        be = '0; wd = '0; ld = '0;
        if (!legal)              flt = 2'd3;
        else if (off % nb != 0)  flt = 2'd1;
        else if (w >= TMO)       flt = 2'd2;
        else                     flt = 2'd0;
        if (legal && (off % nb == 0)) begin
            for (int i = 0; i < nb; i++) be[off + i] = 1'b1;
            for (int i = 0; i < 4; i++) wd[8*i +: 8] = sd[8*(i % nb) +: 8];
        end
        if (flt == 2'd0 && !st) begin
            mask = (64'd1 << (8*nb)) - 64'd1;
            val  = 64'(rd >> (8*off)) & mask;
            if (!f3[2] && nb < 4 && val[8*nb-1]) val = val | ~mask;
            ld = val[31:0];
        end
    endfunction

    // Issue one request from an accepting cycle and follow it to done.
    task automatic do_txn(input string tag, input bit st, input bit [2:0] f3,
                          input bit [31:0] a, input bit [31:0] sd, input bit [31:0] rd,
                          input int w, input bit [1:0] eflt, input bit [31:0] eld,
                          input bit [3:0] ebe, input bit [31:0] ewd);
        int nreq, exp_nreq;
        bit stall0, bus_ok, stall_ok, ended, legal_bus;
        logic [1:0] flt;
        logic [31:0] ld, wd, ma;
        logic [3:0] be;
        logic we;
        nreq = 0; bus_ok = 1; stall_ok = 1; ended = 0;
        flt = '0; ld = '0; wd = '0; ma = '0; be = '0; we = 1'b0;
        mem_ready = 1'b0;
        start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd;
        #1 stall0 = stall;
        next_cycle();
        // Scramble request inputs to confirm the DUT uses latched values.
        start = 1'b0; is_store = 1'($urandom); funct3 = 3'($urandom);
        addr = $urandom; store_data = $urandom;
        for (int c = 0; c < 300 && !ended; c++) begin
            if (mem_req) begin
                if (nreq == 0) begin
                    be = mem_be; wd = mem_wdata; we = mem_we; ma = mem_addr;
                end else if (mem_be !== be || mem_wdata !== wd || mem_we !== we || mem_addr !== ma) begin
                    bus_ok = 0;
                end
                if (!stall || done) stall_ok = 0;
                nreq++;
                mem_ready = (nreq == w + 1);
                mem_rdata = mem_ready ? rd : $urandom;
                next_cycle();
                mem_ready = 1'b0;
            end else if (done) begin
                flt = fault; ld = load_data;
                ended = 1;
            end else begin
                c = 300;
            end
        end
        exp_nreq  = (eflt == 2'd1 || eflt == 2'd3) ? 0 : ((w < TMO) ? w + 1 : TMO);
        legal_bus = (eflt == 2'd0 || eflt == 2'd2);
        check({tag, "_done"}, 32'(ended), 32'd1);
        check({tag, "_fault"}, 32'(flt), 32'(eflt));
        check({tag, "_load_data"}, ld, eld);
        check({tag, "_req_cycles"}, 32'(nreq), 32'(exp_nreq));
        check({tag, "_stall_accept"}, 32'(stall0), 32'(legal_bus));
        check({tag, "_stall_done"}, 32'(stall), 32'd0);
        if (legal_bus) begin
            check({tag, "_mem_be"}, 32'(be), 32'(ebe));
            check({tag, "_mem_we"}, 32'(we), 32'(st));
            check({tag, "_mem_addr"}, ma, {a[31:2], 2'b00});
            check({tag, "_bus_stable"}, 32'(bus_ok), 32'd1);
            check({tag, "_stall_req"}, 32'(stall_ok), 32'd1);
            if (st) check({tag, "_mem_wdata"}, wd, ewd);
        end
    endtask

    initial begin
        bit [1:0] mflt;
        bit [31:0] mld, mwd, ra, rsd, rrd;
        bit [3:0] mbe;
        bit rst_;
        bit [2:0] rf3;
        int rw;
        bit saw_done;

        //        st    f3      addr           sd             rdata          w  flt    ld             be      wd
        vecs[0] = '{1'b0, 3'b010, 32'h1000_0008, 32'h0000_0000, 32'hDEAD_BEEF, 0, 2'd0, 32'hDEAD_BEEF, 4'hF, 32'h0};
        vecs[1] = '{1'b0, 3'b000, 32'h2000_0003, 32'h0000_0000, 32'h8011_2233, 3, 2'd0, 32'hFFFF_FF80, 4'h8, 32'h0};
        vecs[2] = '{1'b0, 3'b100, 32'h2000_0003, 32'h0000_0000, 32'h8011_2233, 3, 2'd0, 32'h0000_0080, 4'h8, 32'h0};
        vecs[3] = '{1'b1, 3'b001, 32'h3000_0002, 32'h0000_ABCD, 32'h1111_1111, 1, 2'd0, 32'h0000_0000, 4'hC, 32'hABCD_ABCD};
        vecs[4] = '{1'b0, 3'b010, 32'h1000_0002, 32'h0000_0000, 32'h1234_5678, 0, 2'd1, 32'h0000_0000, 4'h0, 32'h0};
        vecs[5] = '{1'b1, 3'b011, 32'h1000_0000, 32'h1234_5678, 32'h0000_0000, 0, 2'd3, 32'h0000_0000, 4'h0, 32'h0};
        vecs[6] = '{1'b0, 3'b010, 32'h5000_0004, 32'h0000_0000, 32'h1234_5678, 9, 2'd2, 32'h0000_0000, 4'hF, 32'h0};
        vecs[7] = '{1'b0, 3'b001, 32'h6000_0002, 32'h0000_0000, 32'h8011_2233, 2, 2'd0, 32'hFFFF_8011, 4'hC, 32'h0};
        vecs[8] = '{1'b0, 3'b101, 32'h6000_0000, 32'h0000_0000, 32'h1234_F00D, 0, 2'd0, 32'h0000_F00D, 4'h3, 32'h0};
        vecs[9] = '{1'b1, 3'b000, 32'h7000_0001, 32'h1234_56A5, 32'h0000_0000, 0, 2'd0, 32'h0000_0000, 4'h2, 32'hA5A5_A5A5};

        // Reset state.
        #1 rst_n = 1'b0;
        #2;
        check("reset_outputs", {22'h0, stall, done, fault, mem_req, mem_we, mem_be}, 32'h0);
        check("reset_data", load_data | mem_addr | mem_wdata, 32'h0);
        #9 rst_n = 1'b1;
        next_cycle();
        check("idle_after_reset", {29'h0, stall, done, mem_req}, 32'h0);

        foreach (vecs[i]) begin
            do_txn($sformatf("vec%0d", i), vecs[i].st, vecs[i].f3, vecs[i].a, vecs[i].sd,
                   vecs[i].rd, vecs[i].w, vecs[i].flt, vecs[i].ld, vecs[i].be, vecs[i].wd);
        end

        // Randomized transactions, sometimes separated by an idle cycle.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                mem_ready = 1'($urandom);
                next_cycle();
                check($sformatf("rnd%0d_idle_done", n), 32'(done), 32'd0);
                mem_ready = 1'b0;
            end
            rst_ = 1'($urandom);
            rf3  = ($urandom_range(0, 3) == 0) ? 3'($urandom) :
                   (rst_ ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5)));
            ra   = $urandom;
            rsd  = $urandom;
            rrd  = $urandom;
            rw   = $urandom_range(0, 5);
            model(rst_, rf3, ra, rsd, rrd, rw, mflt, mld, mbe, mwd);
            do_txn($sformatf("rnd%0d", n), rst_, rf3, ra, rsd, rrd, rw, mflt, mld, mbe, mwd);
        end

        // Back-to-back LW then SW, with reset asserted during the SW request.
        do_txn("b2b_first", 1'b0, 3'b010, 32'h4000_0000, 32'h0, 32'hCAFE_F00D, 0,
               2'd0, 32'hCAFE_F00D, 4'hF, 32'h0);
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h4000_0010;
        #1 check("b2b_lw_stall", 32'(stall), 32'd1);
        next_cycle();
        start = 1'b0;
        check("b2b_lw_req", {30'h0, mem_req, mem_we}, 32'h2);
        mem_ready = 1'b1; mem_rdata = 32'h0BAD_CAFE;
        next_cycle();
        mem_ready = 1'b0;
        check("b2b_lw_done", {31'h0, done}, 32'h1);
        check("b2b_lw_data", load_data, 32'h0BAD_CAFE);
        start = 1'b1; is_store = 1'b1; funct3 = 3'b010; addr = 32'h4000_0020; store_data = 32'h0000_55AA;
        #1 check("b2b_sw_stall", 32'(stall), 32'd1);
        next_cycle();
        start = 1'b0;
        check("b2b_sw_req", {30'h0, mem_req, mem_we}, 32'h3);
        check("b2b_sw_addr", mem_addr, 32'h4000_0020);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_req_ctrl", {22'h0, stall, done, fault, mem_req, mem_we, mem_be}, 32'h0);
        check("rst_mid_req_data", load_data | mem_addr | mem_wdata, 32'h0);
        next_cycle();
        rst_n = 1'b1;
        saw_done = 1'b0;
        mem_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            if (done || mem_req) saw_done = 1'b1;
        end
        mem_ready = 1'b0;
        check("rst_no_done", 32'(saw_done), 32'd0);
        do_txn("post_rst", 1'b0, 3'b000, 32'h0000_0001, 32'h0, 32'h0000_7F00, 1,
               2'd0, 32'h0000_007F, 4'h2, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
